// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: detects rising/falling edges on CH_NUM synchronous inputs,
// parks each edge in a one-entry per-channel slot, and serialises the slots onto
// a single valid/ready event stream with round-robin arbitration. Drops caused
// by a still-occupied slot are reported as a one-cycle ovf pulse.
// Optional feature macro: EDGE_ARB_OVF_CNT_EN adds ovf_clr/ovf_cnt and a
// saturating drop counter.
module edge_event_arbiter #(
  parameter int CH_NUM    = 4,
  parameter int IDX_W     = $clog2(CH_NUM),
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    in_s,
  input  logic [CH_NUM-1:0]    mask_rise,
  input  logic [CH_NUM-1:0]    mask_fall,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [IDX_W-1:0]     ev_ch,
  output logic                 ev_fall,
  output logic [CH_NUM-1:0]    pend,
  output logic                 ovf,
`ifdef EDGE_ARB_OVF_CNT_EN
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
`endif
  output logic [IDX_W-1:0]     ovf_ch
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CH_NUM-1:0] prev_q;
  logic              arm_q;
  logic [CH_NUM-1:0] slotFull_q, slotFull_d;
  logic [CH_NUM-1:0] slotFall_q, slotFall_d;
  logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]  evCh_q, evCh_d;
  logic              evFall_q, evFall_d;
  logic              ovf_q, ovf_d;
  logic [IDX_W-1:0]  ovfCh_q, ovfCh_d;

  logic [CH_NUM-1:0] riseEv, fallEv, dropVec, unloadVec;
  logic              grantFound, grantEn, doGrant;
  logic [IDX_W-1:0]  grantIdx;
  logic [IDX_W:0]    candWide;

  // Edges are only recognised once the first post-reset sample has been taken
  assign riseEv = {CH_NUM{arm_q}} & in_s & ~prev_q & ~mask_rise;
  assign fallEv = {CH_NUM{arm_q}} & ~in_s & prev_q & ~mask_fall;

  // A new grant may be issued whenever the stream is idle or the current event is accepted
  assign grantEn = (state_q == IDLE) || ev_ready;
  assign doGrant = grantEn && grantFound;

  // Round-robin search: first full slot starting just after the last granted channel
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candWide   = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      candWide = {1'b0, rrPtr_q} + (IDX_W+1)'(k);
      if (candWide >= (IDX_W+1)'(CH_NUM)) begin
        candWide = candWide - (IDX_W+1)'(CH_NUM);
      end
      if (!grantFound && slotFull_q[candWide[IDX_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candWide[IDX_W-1:0];
      end
    end
  end

  // Stream FSM: load the granted slot into the output register and track IDLE/SEND
  always_comb begin
    state_d   = state_q;
    evCh_d    = evCh_q;
    evFall_d  = evFall_q;
    rrPtr_d   = rrPtr_q;
    unloadVec = '0;
    if (doGrant) begin
      state_d             = SEND;
      evCh_d              = grantIdx;
      evFall_d            = slotFall_q[grantIdx];
      rrPtr_d             = grantIdx;
      unloadVec[grantIdx] = 1'b1;
    end else if ((state_q == SEND) && ev_ready) begin
      state_d = IDLE;
    end
  end

  // Slot update: unload on grant, refill on edge; an edge into an occupied slot is dropped
  always_comb begin
    slotFull_d = slotFull_q;
    slotFall_d = slotFall_q;
    dropVec    = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (unloadVec[i]) begin
        slotFull_d[i] = 1'b0;
      end
      if (riseEv[i] || fallEv[i]) begin
        if (slotFull_q[i] && !unloadVec[i]) begin
          dropVec[i] = 1'b1;
        end else begin
          slotFull_d[i] = 1'b1;
          slotFall_d[i] = fallEv[i];
        end
      end
    end
  end

  // Drop report: single-cycle pulse naming the lowest dropping channel
  always_comb begin
    ovf_d   = |dropVec;
    ovfCh_d = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (dropVec[i]) begin
        ovfCh_d = IDX_W'(i);
      end
    end
  end

  // State registers; reset discards every slot and any event in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      arm_q      <= 1'b0;
      slotFull_q <= '0;
      slotFall_q <= '0;
      rrPtr_q    <= IDX_W'(CH_NUM - 1);
      evCh_q     <= '0;
      evFall_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ovfCh_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= in_s;
      arm_q      <= 1'b1;
      slotFull_q <= slotFull_d;
      slotFall_q <= slotFall_d;
      rrPtr_q    <= rrPtr_d;
      evCh_q     <= evCh_d;
      evFall_q   <= evFall_d;
      ovf_q      <= ovf_d;
      ovfCh_q    <= ovfCh_d;
    end
  end

  assign ev_valid = (state_q == SEND);
  assign ev_ch    = evCh_q;
  assign ev_fall  = evFall_q;
  assign pend     = slotFull_q;
  assign ovf      = ovf_q;
  assign ovf_ch   = ovfCh_q;

`ifdef EDGE_ARB_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovfCnt_q, ovfCnt_d;

  // Saturating drop counter; clear wins over a coincident increment
  always_comb begin
    ovfCnt_d = ovfCnt_q;
    if (ovf_clr) begin
      ovfCnt_d = '0;
    end else if (ovf_q && (ovfCnt_q != {OVF_CNT_W{1'b1}})) begin
      ovfCnt_d = ovfCnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfCnt_q <= '0;
    end else begin
      ovfCnt_q <= ovfCnt_d;
    end
  end

  assign ovf_cnt = ovfCnt_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus randomized traffic, all checked
// against a slot/queue level reference model of the edge arbiter.
module tb_edge_event_arbiter;

  localparam int CH_NUM    = 4;
  localparam int IDX_W     = 2;
  localparam int OVF_CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       in_s = '0;
  logic [3:0]       mask_rise = '0;
  logic [3:0]       mask_fall = '0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic [1:0]       ev_ch;
  logic             ev_fall;
  logic [3:0]       pend;
  logic             ovf;
  logic [1:0]       ovf_ch;
  logic             ovf_clr = 1'b0;
`ifdef EDGE_ARB_OVF_CNT_EN
  logic [7:0]       ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: per-channel slots and the event currently offered
  logic [3:0] mPrev;
  logic       mArm;
  logic [3:0] mFull;
  logic [3:0] mIsFall;
  int         mRr;
  logic       mSend;
  logic [1:0] mCh;
  logic       mEvFall;
  logic       mOvf;
  logic [1:0] mOvfCh;
  int         mCnt;

  edge_event_arbiter #(
    .CH_NUM(CH_NUM),
    .IDX_W(IDX_W),
    .OVF_CNT_W(OVF_CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_s(in_s),
    .mask_rise(mask_rise),
    .mask_fall(mask_fall),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_ch(ev_ch),
    .ev_fall(ev_fall),
    .pend(pend),
    .ovf(ovf),
`ifdef EDGE_ARB_OVF_CNT_EN
    .ovf_clr(ovf_clr),
    .ovf_cnt(ovf_cnt),
`endif
    .ovf_ch(ovf_ch)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Model: everything empty, pointer parked at the last channel
  task automatic modelReset();
    mPrev   = '0;
    mArm    = 1'b0;
    mFull   = '0;
    mIsFall = '0;
    mRr     = CH_NUM - 1;
    mSend   = 1'b0;
    mCh     = '0;
    mEvFall = 1'b0;
    mOvf    = 1'b0;
    mOvfCh  = '0;
    mCnt    = 0;
  endtask

  // Model: one clock edge worth of behaviour from the inputs seen at that edge
  task automatic modelStep(input logic [3:0] inS, input logic [3:0] mr, input logic [3:0] mf,
                           input logic rdy, input logic clr);
    int  g;
    int  firstDrop;
    logic rise, fall;
    if (clr) mCnt = 0;
    else if (mOvf && mCnt < 255) mCnt++;
    g = -1;
    if (!mSend || rdy) begin
      mSend = 1'b0;
      for (int off = 1; off <= CH_NUM; off++) begin
        int idx;
        idx = (mRr + off) % CH_NUM;
        if (g < 0 && mFull[idx]) g = idx;
      end
      if (g >= 0) begin
        mSend    = 1'b1;
        mCh      = 2'(g);
        mEvFall  = mIsFall[g];
        mFull[g] = 1'b0;
        mRr      = g;
      end
    end
    firstDrop = -1;
    for (int i = 0; i < CH_NUM; i++) begin
      rise = mArm && inS[i] && !mPrev[i] && !mr[i];
      fall = mArm && !inS[i] && mPrev[i] && !mf[i];
      if (rise || fall) begin
        if (mFull[i]) begin
          if (firstDrop < 0) firstDrop = i;
        end else begin
          mFull[i]   = 1'b1;
          mIsFall[i] = fall;
        end
      end
    end
    mOvf   = (firstDrop >= 0);
    mOvfCh = mOvf ? 2'(firstDrop) : 2'd0;
    mPrev  = inS;
    mArm   = 1'b1;
  endtask

  // Advance one clock: model follows the edge, outputs are then observed 1 unit later
  task automatic tick();
    logic [3:0] sIn, sMr, sMf;
    logic       sRdy, sClr;
    sIn  = in_s;
    sMr  = mask_rise;
    sMf  = mask_fall;
    sRdy = ev_ready;
    sClr = ovf_clr;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(sIn, sMr, sMf, sRdy, sClr);
    #1;
  endtask

  // Reset pulse with a chosen input level, followed by the arming edge
  task automatic pulseReset(input logic [3:0] level);
    rst_n     = 1'b0;
    in_s      = level;
    mask_rise = '0;
    mask_fall = '0;
    ev_ready  = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    modelReset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reset state, release with 0101 produces nothing, masked fall produces nothing
  task automatic test_reset();
    rst_n     = 1'b0;
    in_s      = 4'b0101;
    mask_rise = '0;
    mask_fall = '0;
    ev_ready  = 1'b0;
    #3;
    modelReset();
    checks++;
    if ({ev_valid, ev_ch, ev_fall, pend, ovf, ovf_ch} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 0", {ev_valid, ev_ch, ev_fall, pend, ovf, ovf_ch});
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (ev_valid !== 1'b0 || pend !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL release_quiet cycle %0d got valid=%b pend=%b want 0/0000", n, ev_valid, pend);
      end
    end
    mask_fall = 4'b0100;
    in_s      = 4'b0001;
    tick();
    mask_fall = '0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL masked_fall_pend got %b want 0000", pend);
    end
  endtask

  // Rising edge on ch2 reaches the stream two edges after it is sampled
  task automatic test_first_edge();
    in_s = 4'b0101;
    tick();
    checks++;
    if (pend !== 4'b0100 || ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_slot got pend=%b valid=%b want 0100/0", pend, ev_valid);
    end
    tick();
    checks++;
    if ({ev_valid, ev_ch, ev_fall, pend} !== {1'b1, 2'd2, 1'b0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL first_event got v=%b ch=%0d f=%b pend=%b want 1/2/0/0000", ev_valid, ev_ch, ev_fall, pend);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_accept got valid=%b want 0", ev_valid);
    end
  endtask

  // Simultaneous edges stream out one per cycle in round-robin order
  task automatic test_back_to_back();
    logic [3:0] pattern [3];
    int         tbRr;
    int         expOrder [$];
    pattern[0] = 4'b1111;
    pattern[1] = 4'b0010;
    pattern[2] = 4'b1111;
    pulseReset(4'b0000);
    tbRr     = CH_NUM - 1;
    ev_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      expOrder.delete();
      for (int off = 1; off <= CH_NUM; off++) begin
        if (pattern[r][(tbRr + off) % CH_NUM]) expOrder.push_back((tbRr + off) % CH_NUM);
      end
      tbRr = expOrder[expOrder.size() - 1];
      in_s = pattern[r];
      tick();
      checks++;
      if (pend !== pattern[r]) begin
        errors++;
        $display("[TB] FAIL b2b_fill round %0d got %b want %b", r, pend, pattern[r]);
      end
      foreach (expOrder[n]) begin
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_ch !== 2'(expOrder[n]) || ev_fall !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_order round %0d slot %0d got v=%b ch=%0d f=%b want 1/%0d/0",
                   r, n, ev_valid, ev_ch, ev_fall, expOrder[n]);
        end
      end
      tick();
      checks++;
      if (ev_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_drain round %0d got valid=%b want 0", r, ev_valid);
      end
      mask_fall = 4'b1111;
      in_s      = 4'b0000;
      tick();
      mask_fall = 4'b0000;
    end
    ev_ready = 1'b0;
  endtask

  // Stalled consumer: a third edge on ch1 hits an occupied slot and is dropped
  task automatic test_overflow();
    in_s = 4'b0010;
    tick();
    tick();
    tick();
    in_s = 4'b0000;
    tick();
    checks++;
    if (pend !== 4'b0010 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_store got pend=%b ovf=%b want 0010/0", pend, ovf);
    end
    tick();
    tick();
    in_s = 4'b0010;
    tick();
    checks++;
    if (ovf !== 1'b1 || ovf_ch !== 2'd1) begin
      errors++;
      $display("[TB] FAIL ovf_pulse got ovf=%b ch=%0d want 1/1", ovf, ovf_ch);
    end
    checks++;
    if ({ev_valid, ev_ch, ev_fall} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_hold got v=%b ch=%0d f=%b want 1/1/0", ev_valid, ev_ch, ev_fall);
    end
    tick();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_width got ovf=%b want 0", ovf);
    end
    ev_ready = 1'b1;
    tick();
    checks++;
    if ({ev_valid, ev_ch, ev_fall} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_next got v=%b ch=%0d f=%b want 1/1/1", ev_valid, ev_ch, ev_fall);
    end
    tick();
    checks++;
    if (ev_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ovf_drain got valid=%b pend=%b want 0/0000", ev_valid, pend);
    end
    ev_ready = 1'b0;
  endtask

  // Masks filter edges but never remove an already pending slot
  task automatic test_mask();
    ev_ready  = 1'b1;
    mask_rise = 4'b1000;
    in_s      = 4'b1010;
    tick();
    mask_rise = 4'b0000;
    ev_ready  = 1'b0;
    mask_fall = 4'b1000;
    in_s      = 4'b0010;
    tick();
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mask_fall_pend got %b want 0000", pend);
    end
    in_s = 4'b1010;
    tick();
    checks++;
    if (pend !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL mask_rise_pend got %b want 1000", pend);
    end
    tick();
    checks++;
    if ({ev_valid, ev_ch, ev_fall, pend} !== {1'b1, 2'd3, 1'b0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL mask_event got v=%b ch=%0d f=%b pend=%b want 1/3/0/0000", ev_valid, ev_ch, ev_fall, pend);
    end
    mask_fall = 4'b0000;
    in_s      = 4'b0010;
    tick();
    mask_fall = 4'b1000;
    tick();
    checks++;
    if (pend !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL mask_keeps_slot got %b want 1000", pend);
    end
    ev_ready = 1'b1;
    tick();
    checks++;
    if ({ev_valid, ev_ch, ev_fall} !== {1'b1, 2'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mask_late_fall got v=%b ch=%0d f=%b want 1/3/1", ev_valid, ev_ch, ev_fall);
    end
    tick();
    mask_fall = 4'b0000;
    ev_ready  = 1'b0;
  endtask

  // Asynchronous reset in the middle of a handshake flushes everything
  task automatic test_reset_mid();
    in_s = ~in_s;
    tick();
    tick();
    checks++;
    if (ev_valid !== mSend || pend !== mFull) begin
      errors++;
      $display("[TB] FAIL mid_setup got v=%b pend=%b want %b/%b", ev_valid, pend, mSend, mFull);
    end
    ev_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if (ev_valid !== 1'b0 || pend !== 4'b0000 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got v=%b pend=%b ovf=%b want 0/0000/0", ev_valid, pend, ovf);
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (ev_valid !== 1'b0 || pend !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL mid_stale cycle %0d got v=%b pend=%b want 0/0000", n, ev_valid, pend);
      end
    end
    ev_ready = 1'b0;
  endtask

  // Random levels, masks and back-pressure compared every cycle with the model
  task automatic test_random();
    pulseReset(4'($urandom));
    for (int n = 0; n < 800; n++) begin
      in_s      = 4'($urandom);
      mask_rise = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      mask_fall = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      ev_ready  = ($urandom_range(0, 9) < 6);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (ev_valid !== mSend) begin
        errors++;
        $display("[TB] FAIL rand_valid cycle %0d got %b want %b", n, ev_valid, mSend);
      end
      if (mSend) begin
        checks++;
        if (ev_ch !== mCh || ev_fall !== mEvFall) begin
          errors++;
          $display("[TB] FAIL rand_event cycle %0d got ch=%0d f=%b want %0d/%b", n, ev_ch, ev_fall, mCh, mEvFall);
        end
      end
      checks++;
      if (pend !== mFull) begin
        errors++;
        $display("[TB] FAIL rand_pend cycle %0d got %b want %b", n, pend, mFull);
      end
      checks++;
      if (ovf !== mOvf) begin
        errors++;
        $display("[TB] FAIL rand_ovf cycle %0d got %b want %b", n, ovf, mOvf);
      end
      if (mOvf) begin
        checks++;
        if (ovf_ch !== mOvfCh) begin
          errors++;
          $display("[TB] FAIL rand_ovf_ch cycle %0d got %0d want %0d", n, ovf_ch, mOvfCh);
        end
      end
`ifdef EDGE_ARB_OVF_CNT_EN
      checks++;
      if (ovf_cnt !== 8'(mCnt)) begin
        errors++;
        $display("[TB] FAIL rand_ovf_cnt cycle %0d got %0d want %0d", n, ovf_cnt, mCnt);
      end
`endif
    end
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
  endtask

`ifdef EDGE_ARB_OVF_CNT_EN
  // Saturation after many drops, then clear beats a coincident increment
  task automatic test_ovf_count();
    pulseReset(4'b0000);
    in_s = 4'b0001;
    tick();
    tick();
    in_s = 4'b0000;
    tick();
    for (int n = 0; n < 300; n++) begin
      in_s = {3'b000, ~in_s[0]};
      tick();
    end
    tick();
    checks++;
    if (ovf_cnt !== 8'hFF || ovf_cnt !== 8'(mCnt)) begin
      errors++;
      $display("[TB] FAIL cnt_saturate got %0d want 255 (model %0d)", ovf_cnt, mCnt);
    end
    ovf_clr = 1'b1;
    in_s    = {3'b000, ~in_s[0]};
    tick();
    checks++;
    if (ovf_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL cnt_clear got %0d want 0", ovf_cnt);
    end
    tick();
    checks++;
    if (ovf_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL cnt_clear_priority got %0d want 0", ovf_cnt);
    end
    ovf_clr = 1'b0;
    tick();
    checks++;
    if (ovf_cnt !== 8'(mCnt)) begin
      errors++;
      $display("[TB] FAIL cnt_resume got %0d want %0d", ovf_cnt, mCnt);
    end
  endtask
`endif

  // Scenario sequence and summary
  initial begin
    modelReset();
    test_reset();
    test_first_edge();
    test_back_to_back();
    test_overflow();
    test_mask();
    test_reset_mid();
    test_random();
`ifdef EDGE_ARB_OVF_CNT_EN
    test_ovf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
